// File: rtl/aes_enc_iter.sv
// Iterative AES-128 encryptor: ROUNDS_PER_CYCLE unrolled rounds per clock with
// on-the-fly key expansion, optional CBC chaining and a valid/ready stream port.

module aes_enc_round (
  input  logic [127:0] data_i,
  input  logic [127:0] rk_i,
  input  logic [3:0]   rnd_i,
  output logic [127:0] data_o,
  output logic [127:0] rk_o
);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[x];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Byte b of the state sits at column b/4, row b%4; byte 0 is the MSB.
  logic [0:15][7:0] din, sb, sr;
  logic [127:0]     sr_v, mc;
  logic [31:0]      w0, w1, w2, w3, t, n0, n1, n2, n3;

  assign din = data_i;

  for (genvar i = 0; i < 16; i++) begin : g_sub
    assign sb[i] = sbox(din[i]);
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sr[r+4*c] = sb[r+4*((c+r)%4)];
    end
    assign mc[127-32*c -: 32] = mix_col({sr[4*c], sr[4*c+1], sr[4*c+2], sr[4*c+3]});
  end

  assign sr_v = sr;

  assign {w0, w1, w2, w3} = rk_i;
  assign t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
              ^ {rcon(rnd_i), 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign rk_o = {n0, n1, n2, n3};

  assign data_o = ((rnd_i == 4'd10) ? sr_v : mc) ^ rk_o;

endmodule

module aes_enc_iter #(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter bit CBC_EN           = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] key,
  input  logic         key_load,
  input  logic [127:0] iv,
  input  logic         iv_load,
  input  logic         mode,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
  output logic         busy
);

  localparam int R = ROUNDS_PER_CYCLE;

  if (!(R == 1 || R == 2 || R == 5 || R == 10)) begin : g_bad_r
    $error("aes_enc_iter: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
  end

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_e;

  state_e       state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] key_q, key_d;
  logic [127:0] chain_q, chain_d;
  logic         mode_q, mode_d;
  logic [127:0] rk_q, rk_d;
  logic [127:0] data_q, data_d;
  logic [127:0] ct_q, ct_d;

  logic [127:0] k0, iv_eff, blk_in, rnd_dat, rnd_key;
  logic         accept, cbc_sel, last;

  // Round j of this cycle consumes the output of round j-1 combinationally.
  for (genvar j = 0; j < R; j++) begin : g_rnd
    logic [127:0] d_in, k_in, d_out, k_out;
    if (j == 0) begin : g_first
      assign d_in = data_q;
      assign k_in = rk_q;
    end else begin : g_next
      assign d_in = g_rnd[j-1].d_out;
      assign k_in = g_rnd[j-1].k_out;
    end
    aes_enc_round u_round (
      .data_i (d_in),
      .rk_i   (k_in),
      .rnd_i  (rnd_q + 4'(j)),
      .data_o (d_out),
      .rk_o   (k_out)
    );
  end

  assign rnd_dat = g_rnd[R-1].d_out;
  assign rnd_key = g_rnd[R-1].k_out;

  assign in_ready   = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
  assign out_valid  = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
  assign ciphertext = ct_q;

  // Loads are only honoured when the engine could accept a block this cycle.
  assign accept  = in_valid & in_ready;
  assign k0      = (key_load & in_ready) ? key : key_q;
  assign iv_eff  = (iv_load & in_ready) ? iv : chain_q;
  assign cbc_sel = mode & CBC_EN;
  assign blk_in  = plaintext ^ k0 ^ (cbc_sel ? iv_eff : 128'h0);
  assign last    = (rnd_q + 4'(R - 1)) == 4'd10;

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    data_d  = data_q;
    rk_d    = rk_q;
    ct_d    = ct_q;
    key_d   = k0;
    chain_d = iv_eff;
    mode_d  = mode_q;
    case (state_q)
      S_RUN: begin
        data_d = rnd_dat;
        rk_d   = rnd_key;
        rnd_d  = rnd_q + 4'(R);
        if (last) begin
          rnd_d   = 4'd10;
          ct_d    = rnd_dat;
          state_d = S_DONE;
          if (mode_q) chain_d = rnd_dat;
        end
      end
      S_DONE:  if (out_ready && !accept) state_d = S_IDLE;
      S_IDLE:  ;
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      data_d  = blk_in;
      rk_d    = k0;
      rnd_d   = 4'd1;
      mode_d  = cbc_sel;
      state_d = S_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rnd_q   <= 4'd0;
      key_q   <= '0;
      rk_q    <= '0;
      data_q  <= '0;
      ct_q    <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      key_q   <= key_d;
      rk_q    <= rk_d;
      data_q  <= data_d;
      ct_q    <= ct_d;
    end
  end

  if (CBC_EN) begin : g_cbc
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        chain_q <= '0;
        mode_q  <= 1'b0;
      end else begin
        chain_q <= chain_d;
        mode_q  <= mode_d;
      end
    end
  end else begin : g_ecb
    logic unused_cbc;
    assign chain_q    = '0;
    assign mode_q     = 1'b0;
    assign unused_cbc = ^{chain_d, mode_d};
  end

endmodule

// File: tb/tb_aes_enc_iter.sv
// Bench for aes_enc_iter: five builds (R=1,2,5,10 with CBC, R=1 ECB-only) share
// one stimulus stream; results are compared to known answers and an array-based model.
module tb_aes_enc_iter;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic [127:0] key = '0, iv = '0, plaintext = '0;
  logic         key_load = 1'b0, iv_load = 1'b0, mode = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [4:0]   ov, ir, bz;
  logic [127:0] ct [5];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    aes_enc_iter #(
      .ROUNDS_PER_CYCLE(g == 1 ? 2 : g == 2 ? 5 : g == 3 ? 10 : 1),
      .CBC_EN(g != 4)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .key(key), .key_load(key_load), .iv(iv), .iv_load(iv_load),
      .mode(mode), .in_valid(in_valid), .in_ready(ir[g]), .plaintext(plaintext),
      .out_valid(ov[g]), .out_ready(out_ready), .ciphertext(ct[g]), .busy(bz[g])
    );
  end

  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PB  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CB  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] IV0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] S1  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] S2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] CS1 = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] CS2 = 128'h5086cb9b507219ee95db113a917678b2;
  localparam logic [127:0] ES1 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;

  int checks = 0, errors = 0;
  int expl [5] = '{10, 5, 2, 1, 10};
  int lat [5];
  logic [7:0]   sbox_m [256];
  logic [127:0] key_m, ivr, pr, kr;
  logic [127:0] chain_m [5];
  logic [127:0] exp_ct [5];
  logic         seen, kl, il, md;
  int           n;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int s);
    logic [15:0] t;
    t = {b, b} << s;
    return t[15:8];
  endfunction

  // S-box from its definition: GF(2^8) inverse found by search, then the affine map.
  task automatic gen_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_model(input logic [127:0] k, input logic [127:0] p);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a [4];
    logic [7:0]   rc;
    logic [31:0]  tw;
    logic [127:0] o;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tw = w[i-1];
      if (i % 4 == 0) begin
        tw = {sbox_m[tw[23:16]], sbox_m[tw[15:8]], sbox_m[tw[7:0]], sbox_m[tw[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tw;
    end
    for (int b = 0; b < 16; b++) s[b] = p[127-8*b -: 8] ^ w[b/4][31-8*(b%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int b = 0; b < 16; b++) t[b] = sbox_m[s[b]];
      for (int b = 0; b < 16; b++) s[b] = t[(b%4) + 4*(((b/4) + (b%4)) % 4)];
      if (r < 10)
        for (int c = 0; c < 4; c++) begin
          for (int j = 0; j < 4; j++) a[j] = s[4*c+j];
          s[4*c]   = gmul(a[0], 8'h02) ^ gmul(a[1], 8'h03) ^ a[2] ^ a[3];
          s[4*c+1] = a[0] ^ gmul(a[1], 8'h02) ^ gmul(a[2], 8'h03) ^ a[3];
          s[4*c+2] = a[0] ^ a[1] ^ gmul(a[2], 8'h02) ^ gmul(a[3], 8'h03);
          s[4*c+3] = gmul(a[0], 8'h03) ^ a[1] ^ a[2] ^ gmul(a[3], 8'h02);
        end
      for (int b = 0; b < 16; b++) s[b] = s[b] ^ w[4*r + b/4][31-8*(b%4) -: 8];
    end
    for (int b = 0; b < 16; b++) o[127-8*b -: 8] = s[b];
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic submit(input logic [127:0] k, input logic kl_i, input logic [127:0] v,
                        input logic il_i, input logic m, input logic [127:0] p);
    key = k; key_load = kl_i; iv = v; iv_load = il_i; mode = m; plaintext = p; in_valid = 1'b1;
    tick();
    key_load = 1'b0; iv_load = 1'b0; in_valid = 1'b0;
  endtask

  task automatic wait_all(input int maxc);
    for (int i = 0; i < 5; i++) lat[i] = -1;
    for (int c = 1; c <= maxc; c++) begin
      tick();
      for (int i = 0; i < 5; i++) if (lat[i] < 0 && ov[i]) lat[i] = c;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    gen_sbox();

    // reset state, sampled while reset is held
    #12;
    chk("rst_ov", ov, 0);
    chk("rst_bz", bz, 0);
    for (int i = 0; i < 5; i++) chk($sformatf("rst_ct%0d", i), ct[i], 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("rst_ir", ir, 5'h1f);

    // FIPS-197 B on every build: latency 10/R
    submit(KB, 1'b1, '0, 1'b0, 1'b0, PB);
    wait_all(12);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("B_lat%0d", i), lat[i], expl[i]);
      chk($sformatf("B_ct%0d", i), ct[i], CB);
    end
    chk("B_ir_stall", ir, 0);
    drain();
    chk("B_drained", ov, 0);

    // C.1 with key_load + iv_load + CBC accept in one cycle; ECB-only build ignores iv
    ivr = rnd128();
    submit(K1, 1'b1, ivr, 1'b1, 1'b1, P1);
    wait_all(12);
    for (int i = 0; i < 4; i++) chk($sformatf("C1cbc_ct%0d", i), ct[i], aes_model(K1, P1 ^ ivr));
    chk("C1_ecbonly_ct", ct[4], C1);
    chk("C1_ecbonly_lat", lat[4], 10);
    drain();

    // SP800-38A CBC back-to-back, second block accepted in the DONE cycle
    out_ready = 1'b1;
    submit(KB, 1'b1, IV0, 1'b1, 1'b1, S1);
    n = 0;
    for (int c = 1; c <= 12 && n == 0; c++) begin
      tick();
      if (ov[0]) n = c;
    end
    chk("cbc1_lat", n, 10);
    chk("cbc1_ct", ct[0], CS1);
    chk("cbc2_ir_in_done", ir[0], 1'b1);
    submit(KB, 1'b0, IV0, 1'b0, 1'b1, S2);
    chk("cbc2_run", {ov[0], bz[0]}, 2'b01);
    n = 0;
    for (int c = 1; c <= 12 && n == 0; c++) begin
      tick();
      if (ov[0]) n = c;
    end
    chk("cbc2_lat", n, 10);
    for (int i = 0; i < 4; i++) chk($sformatf("cbc2_ct%0d", i), ct[i], CS2);
    chk("cbc2_ecbonly_ct", ct[4], aes_model(KB, S2));
    tick();
    out_ready = 1'b0;
    chk("cbc_idle", bz, 0);

    // ECB stall for 20 cycles with a key_load pulse that must be ignored
    submit(KB, 1'b0, '0, 1'b0, 1'b0, S1);
    wait_all(12);
    for (int c = 0; c < 20; c++) begin
      if (c == 5) begin key = rnd128(); key_load = 1'b1; end
      chk($sformatf("stall%0d", c), {ov[0], ir[0], ct[0]}, {1'b1, 1'b0, ES1});
      tick();
      key_load = 1'b0;
    end
    drain();
    pr = rnd128();
    submit(rnd128(), 1'b0, '0, 1'b0, 1'b0, pr);
    wait_all(12);
    for (int i = 0; i < 5; i++) chk($sformatf("stall_key_kept%0d", i), ct[i], aes_model(KB, pr));
    drain();

    // asynchronous reset in the middle of a block (rnd=5 on the R=1 build)
    submit(K1, 1'b1, '0, 1'b0, 1'b0, P1);
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ov", ov, 0);
    chk("midrst_bz", bz, 0);
    for (int i = 0; i < 5; i++) chk($sformatf("midrst_ct%0d", i), ct[i], 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("midrst_ir", ir, 5'h1f);
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      seen = seen | (|ov);
    end
    chk("midrst_no_out", seen, 1'b0);
    submit(K1, 1'b1, '0, 1'b0, 1'b0, P1);
    wait_all(12);
    for (int i = 0; i < 5; i++) chk($sformatf("resub_ct%0d", i), ct[i], C1);
    drain();

    // randomized blocks against the model; chain registers are zero since reset
    key_m = K1;
    for (int i = 0; i < 5; i++) chain_m[i] = '0;
    for (int it = 0; it < 10; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        kr = rnd128();
        key = kr; key_load = 1'b1;
        tick();
        key_load = 1'b0;
        key_m = kr;
      end
      kr = rnd128(); ivr = rnd128(); pr = rnd128();
      kl = 1'($urandom_range(0, 1));
      il = 1'($urandom_range(0, 1));
      md = 1'($urandom_range(0, 1));
      submit(kr, kl, ivr, il, md, pr);
      if (kl) key_m = kr;
      for (int i = 0; i < 5; i++) begin
        if (il && i < 4) chain_m[i] = ivr;
        exp_ct[i] = aes_model(key_m, pr ^ ((md && i < 4) ? chain_m[i] : 128'h0));
        if (md && i < 4) chain_m[i] = exp_ct[i];
      end
      wait_all(12);
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("rand%0d_ct%0d", it, i), ct[i], exp_ct[i]);
        chk($sformatf("rand%0d_lat%0d", it, i), lat[i], expl[i]);
      end
      drain();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_enc_iter.md
# aes_enc_iter

Iterative, parametrised AES-128 encryption engine with registered round state, on-the-fly key expansion and a valid/ready stream interface. Each block is processed over 10/ROUNDS_PER_CYCLE clock cycles. Both ECB and CBC chaining are supported and selected per block. It replaces the purely combinational ECB encryptor in the datapath. The unroll parameter trades area against latency, and the handshake allows stalls on either side.

## Interface
- ROUNDS_PER_CYCLE, 1, AES rounds evaluated per clock; legal values 1, 2, 5, 10; any other value is a elaboration error.
- CBC_EN, 1, 1 = CBC logic present; 0 = mode input ignored, ECB only, chain register removed.

Ports (all 128-bit buses: bit 127 = byte 0 of FIPS-197 state):
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- key  in  128  cipher key.
- key_load  in  1  capture key into the key register.
- iv  in  128  CBC initialisation vector.
- iv_load  in  1  capture iv into the chain register.
- mode  in  1  0 = ECB, 1 = CBC; sampled at block acceptance.
- in_valid  in  1  plaintext valid.
- in_ready  out  1  engine can accept a block.
- plaintext  in  128  input block.
- out_valid  out  1  ciphertext valid.
- out_ready  in  1  downstream accepts ciphertext.
- ciphertext  out  128  output block, registered.
- busy  out  1  high in RUN or DONE.

## Operation
- The FSM has three states: IDLE, RUN and DONE. A 4-bit round counter rnd counts 1..10.
- **in_ready** = (state==IDLE) | (state==DONE & out_ready).
- **Accept** happens when in_valid & in_ready. On accept:
  - state ← plaintext ^ K0 ^ (mode&CBC_EN ? chain : 0), where K0 is the effective key.
  - Working round key ← K0; rnd ← 1; FSM → RUN.
  - The effective key is `key` if key_load is high in the same cycle, otherwise the key register.
  - The effective chain is `iv` if iv_load is high in the same cycle, otherwise the chain register.
- **key_load / iv_load** are honoured only when in_ready = 1. They are ignored in RUN, and in DONE while out_ready = 0. Key and chain registers persist across blocks.
- **RUN**: each cycle applies ROUNDS_PER_CYCLE rounds, chained combinationally.
  - Rounds 1–9: SubBytes, ShiftRows, MixColumns, AddRoundKey.
  - Round 10: MixColumns omitted.
  - Round key i is derived from round key i-1 using RotWord/SubWord/Rcon, with Rcon = 01,02,04,08,10,20,40,80,1b,36.
  - rnd advances by ROUNDS_PER_CYCLE each cycle. When round 10 completes, ciphertext ← result and FSM → DONE.
- **CBC chain update**: when round 10 completes with CBC selected, chain ← result.
- **DONE**: out_valid = 1 and ciphertext is held stable until out_valid & out_ready.
  - If out_ready is high and a new block is accepted in the same cycle, the FSM goes to RUN. That block chains on the ciphertext just delivered.
  - If out_ready is high with no new block, the FSM goes to IDLE.
- The S-box is shared by a common function. There are 16 data instances plus 4 key-schedule instances per unrolled round.

## Timing
- **Reset** (rst_n low, asynchronous):
  - state = IDLE, rnd = 0.
  - key, chain, round key and data registers = 0.
  - ciphertext = 0, out_valid = 0, busy = 0; in_ready = 1 after reset release.
  - Reset during RUN or DONE discards the block and emits no out_valid.
- **Latency**: a block accepted at edge E0 gives out_valid = 1 after edge E0 + 10/ROUNDS_PER_CYCLE. That is 10, 5, 2 or 1 cycles for R = 1, 2, 5, 10.
- **Throughput**: with out_ready held high, one block every 10/R cycles, since acceptance overlaps DONE.
- During RUN, in_ready = 0; in_valid is ignored and plaintext may change.
- Inputs key, iv and plaintext are sampled only on the accept or load edge.
- **Simultaneous key_load + iv_load + accept**: both new values apply to the accepted block.
- **mode** change between blocks: a CBC block after an ECB block uses the chain register unchanged. ECB blocks do not update the chain register.

## Test plan
- **FIPS-197 C.1 (ECB, R=1)**: key_load key=000102030405060708090a0b0c0d0e0f with plaintext 00112233445566778899aabbccddeeff in the same cycle → ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 10 cycles after accept.
- **FIPS-197 B, R ∈ {2,5,10}**: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 → 3925841d02dc09fbdc118597196a0b32, at latency 5, 2 and 1 respectively.
- **SP800-38A CBC, back-to-back with out_ready=1**: key 2b7e1516…4f3c, iv 000102030405060708090a0b0c0d0e0f.
  - P1 6bc1bee22e409f96e93d7e117393172a → 7649abac8119b246cee98e9b12e9197d.
  - P2 ae2d8a571e03ac9c9eb76fac45af8e51 → 5086cb9b507219ee95db113a917678b2.
  - P2 is accepted in the DONE cycle of P1.
- **ECB P1 6bc1bee2…172a, same key, out_ready=0 for 20 cycles**:
  - Ciphertext 3ad77bb40d7a3660a89ecaf32466ef97 is held stable with out_valid = 1.
  - in_ready = 0 throughout; key_load pulsed during the stall has no effect.
- **Reset asserted at rnd=5**:
  - All outputs go to 0 immediately (asynchronous); in_ready = 1 after release.
  - Resubmitting C.1 with key_load gives the correct ciphertext.
- **CBC_EN=0 build with mode=1**: output equals ECB result 69c4e0d86a7b0430d8cdb78070b4c55a for the C.1 vector, with iv ignored.
